// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: decodes MEM-stage accesses to a word RAM or a small MMIO register file.
// Latency: reads are combinational in the cycle ena_rd is high; writes take effect at the next rising edge.
// Backpressure: none; every access completes in the cycle it is presented, so there is no ready or credit path.
//
// Ports:
//   CLOCK, RST            rising-edge clock, asynchronous active-high reset
//   ena_rd, ena_wr        read/write request from the core's MEM stage
//   alu_out_ext           byte address (bits [1:0] ignored, word access only)
//   dataram_wr            write data
//   dataram_rd            read data, 0 when not reading or address unmapped
//   gpio_in               asynchronous external inputs (synchronised internally)
//   gpio_out              GPIO_OUT register
//   timer_irq             timer interrupt level (FLAG && EN), driven from a flop
//   bus_err               one-cycle pulse after an access to an unmapped address
//
// MMIO map (offset from MMIO_BASE):
//   0x00 GPIO_OUT RW, 0x04 GPIO_IN RO, 0x08 CYCLE RO, 0x0C TIMER_CMP RW,
//   0x10 TIMER_STAT {EN(RW), FLAG(W1C)}, 0x14..0x3C read 0 / writes ignored.

module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0000_8000,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              ena_rd,
  input  logic              ena_wr,
  input  logic [31:0]       alu_out_ext,
  input  logic [31:0]       dataram_wr,
  output logic [31:0]       dataram_rd,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  // Word offsets inside the 64-byte MMIO window.
  localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
  localparam logic [3:0] OFF_CYCLE    = 4'h2;
  localparam logic [3:0] OFF_CMP      = 4'h3;
  localparam logic [3:0] OFF_STAT     = 4'h4;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          ram_hit;
  logic          mmio_hit;
  logic          unmapped;
  logic          acc_vld;
  logic [AW-1:0] ram_idx;
  logic [3:0]    mmio_off;
  logic          unused_addr_lsb;

  // Byte-address bits [1:0] select nothing: accesses are whole words.
  assign unused_addr_lsb = ^alu_out_ext[1:0];

  // addr < 4*RAM_WORDS is the same as all bits above the word index being zero.
  assign ram_hit  = (alu_out_ext[31:AW+2] == '0);
  // MMIO_BASE is 64-byte aligned, so the window is one value of addr[31:6].
  // RAM takes priority should the two ranges ever be parameterised to overlap.
  assign mmio_hit = !ram_hit && (alu_out_ext[31:6] == MMIO_BASE[31:6]);
  assign unmapped = !ram_hit && !mmio_hit;
  assign acc_vld  = ena_rd || ena_wr;
  assign ram_idx  = alu_out_ext[AW+1:2];
  assign mmio_off = alu_out_ext[5:2];

  // MMIO write strobes. Writes to GPIO_IN, CYCLE and the reserved words
  // decode to nothing and are silently dropped.
  logic wr_mmio;
  logic wr_gpio;
  logic wr_cmp;
  logic wr_stat;

  assign wr_mmio = ena_wr && mmio_hit;
  assign wr_gpio = wr_mmio && (mmio_off == OFF_GPIO_OUT);
  assign wr_cmp  = wr_mmio && (mmio_off == OFF_CMP);
  assign wr_stat = wr_mmio && (mmio_off == OFF_STAT);

  // ---------------------------------------------------------------------------
  // Data RAM: synchronous write, asynchronous read, contents never reset.
  // A same-cycle read of the written word sees the old contents because the
  // array only updates at the edge.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_mem [0:RAM_WORDS-1];

  always_ff @(posedge CLOCK) begin
    if (ena_wr && ram_hit) begin
      ram_mem[ram_idx] <= dataram_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // MMIO registers
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] gpio_meta_q;
  logic [GPIO_W-1:0] gpio_sync_q;
  logic [31:0]       cycle_q;
  logic [31:0]       cmp_q;
  logic              flag_q;
  logic              en_q;
  logic              irq_q;
  logic              bus_err_q;

  // Timer next-state. A compare match outranks a W1C in the same cycle so an
  // interrupt is never lost to a clear that raced it.
  logic timer_match;
  logic flag_nxt;
  logic en_nxt;

  always_comb begin
    timer_match = en_q && (cycle_q == cmp_q);
    en_nxt      = wr_stat ? dataram_wr[1] : en_q;
    flag_nxt    = flag_q;
    if (timer_match) begin
      flag_nxt = 1'b1;
    end else if (wr_stat && dataram_wr[0]) begin
      flag_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      gpio_out_q  <= '0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
      cycle_q     <= '0;
      cmp_q       <= 32'hFFFF_FFFF;
      flag_q      <= 1'b0;
      en_q        <= 1'b0;
      irq_q       <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      // Two-flop synchroniser for the asynchronous GPIO inputs.
      gpio_meta_q <= gpio_in;
      gpio_sync_q <= gpio_meta_q;

      // Free-running; natural 32-bit wrap.
      cycle_q <= cycle_q + 32'd1;

      if (wr_gpio) begin
        gpio_out_q <= dataram_wr[GPIO_W-1:0];
      end
      if (wr_cmp) begin
        cmp_q <= dataram_wr;
      end

      flag_q <= flag_nxt;
      en_q   <= en_nxt;
      // The interrupt is its own flop loaded with the AND of the next-state
      // values, so the pin equals FLAG && EN but never glitches when both
      // sources change on the same edge.
      irq_q  <= flag_nxt && en_nxt;

      bus_err_q <= acc_vld && unmapped;
    end
  end

  assign gpio_out  = gpio_out_q;
  assign timer_irq = irq_q;
  assign bus_err   = bus_err_q;

  // ---------------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    case (mmio_off)
      OFF_GPIO_OUT: mmio_rd = 32'(gpio_out_q);
      OFF_GPIO_IN:  mmio_rd = 32'(gpio_sync_q);
      OFF_CYCLE:    mmio_rd = cycle_q;
      OFF_CMP:      mmio_rd = cmp_q;
      OFF_STAT:     mmio_rd = {30'd0, en_q, flag_q};
      default:      mmio_rd = '0;
    endcase
  end

  // MMIO reads are held at zero while RST is asserted; RAM reads pass through
  // because the array itself is not reset.
  always_comb begin
    dataram_rd = '0;
    if (ena_rd) begin
      if (ram_hit) begin
        dataram_rd = ram_mem[ram_idx];
      end else if (mmio_hit && !RST) begin
        dataram_rd = mmio_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB      = 32'h0000_8000;
  localparam logic [31:0] A_GOUT  = MB + 32'h00;
  localparam logic [31:0] A_GIN   = MB + 32'h04;
  localparam logic [31:0] A_CYC   = MB + 32'h08;
  localparam logic [31:0] A_CMP   = MB + 32'h0C;
  localparam logic [31:0] A_STAT  = MB + 32'h10;

  logic        CLOCK;
  logic        RST;
  logic        ena_rd;
  logic        ena_wr;
  logic [31:0] alu_out_ext;
  logic [31:0] dataram_wr;
  logic [31:0] dataram_rd;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_err;

  int          n_pass;
  int          n_total;
  int          n_fail;
  logic [31:0] cyc;   // model of the CYCLE counter
  logic [31:0] w;

  dmem_mmio_responder #(
    .RAM_WORDS (1024),
    .MMIO_BASE (32'h0000_8000),
    .GPIO_W    (8)
  ) dut (
    .CLOCK       (CLOCK),
    .RST         (RST),
    .ena_rd      (ena_rd),
    .ena_wr      (ena_wr),
    .alu_out_ext (alu_out_ext),
    .dataram_wr  (dataram_wr),
    .dataram_rd  (dataram_rd),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq),
    .bus_err     (bus_err)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
    cyc = cyc + 32'd1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    ena_rd      = rd;
    ena_wr      = wr;
    alu_out_ext = a;
    dataram_wr  = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    #1;
    chk(tag, dataram_rd, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    tick();
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    cyc     = 0;
    RST     = 1'b1;
    gpio_in = 8'h00;
    idle();

    // ---- reset state ----
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_gpio_out", {24'd0, gpio_out}, 32'h0);
    chk("rst_irq", {31'd0, timer_irq}, 32'h0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'h0);
    rd_chk("rst_mmio_rd_zero", A_CMP, 32'h0);

    RST = 1'b0;
    cyc = 0;
    rd_chk("cycle_first", A_CYC, 32'h0);
    tick();
    rd_chk("cycle_second", A_CYC, 32'h1);
    rd_chk("cmp_reset", A_CMP, 32'hFFFF_FFFF);
    tick();
    rd_chk("stat_reset", A_STAT, 32'h0);

    // ---- RAM ----
    wr(32'h10, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h10, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    #1;
    chk("ram_rdwr_old", dataram_rd, 32'hDEAD_BEEF);
    tick();
    rd_chk("ram_rdwr_new_alias13", 32'h13, 32'h1234_5678);
    wr(32'h0, 32'h1111_1111);
    wr(32'hFFC, 32'hCAFE_F00D);
    rd_chk("ram_last_word", 32'hFFC, 32'hCAFE_F00D);
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    chk("rd_low_zero", dataram_rd, 32'h0);
    tick();

    // ---- GPIO / RO registers ----
    wr(A_GOUT, 32'h0000_00A5);
    chk("gpio_out", {24'd0, gpio_out}, 32'hA5);
    rd_chk("gpio_out_rd", A_GOUT, 32'hA5);
    tick();
    wr(A_CYC, 32'h0);
    rd_chk("cycle_ro", A_CYC, cyc);
    wr(A_GIN, 32'hFF);
    rd_chk("gpio_in_ro", A_GIN, 32'h0);
    gpio_in = 8'h3C;
    tick();
    rd_chk("gpio_sync_1", A_GIN, 32'h0);
    tick();
    rd_chk("gpio_sync_2", A_GIN, 32'h3C);

    // ---- reserved words ----
    rd_chk("reserved_rd", MB + 32'h14, 32'h0);
    tick();
    chk("reserved_rd_no_err", {31'd0, bus_err}, 32'h0);
    wr(MB + 32'h3C, 32'hFFFF_FFFF);
    chk("reserved_wr_no_err", {31'd0, bus_err}, 32'h0);
    rd_chk("reserved_wr_ignored", MB + 32'h3C, 32'h0);
    tick();

    // ---- timer compare ----
    idle();
    w = cyc + 32'd20;
    wr(A_CMP, w);
    wr(A_STAT, 32'h2);
    rd_chk("stat_en", A_STAT, 32'h2);
    idle();
    while (cyc != w) tick();
    chk("irq_at_match", {31'd0, timer_irq}, 32'h0);
    tick();
    chk("irq_rise", {31'd0, timer_irq}, 32'h1);
    rd_chk("stat_flag_en", A_STAT, 32'h3);
    tick();
    wr(A_STAT, 32'h3);
    chk("irq_w1c", {31'd0, timer_irq}, 32'h0);

    // W1C in the same cycle as a match: set wins
    w = cyc + 32'd5;
    wr(A_CMP, w);
    while (cyc != w) tick();
    wr(A_STAT, 32'h3);
    chk("w1c_vs_set", {31'd0, timer_irq}, 32'h1);

    // EN=0 keeps FLAG
    wr(A_STAT, 32'h0);
    chk("irq_en_off", {31'd0, timer_irq}, 32'h0);
    rd_chk("flag_kept", A_STAT, 32'h1);
    tick();
    wr(A_STAT, 32'h1);
    rd_chk("flag_cleared", A_STAT, 32'h0);
    tick();

    // ---- counter wrap ----
    wr(A_CMP, 32'h0);
    wr(A_STAT, 32'h2);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    cyc = 32'hFFFF_FFFE;
    rd_chk("wrap_fe", A_CYC, 32'hFFFF_FFFE);
    tick();
    rd_chk("wrap_ff", A_CYC, 32'hFFFF_FFFF);
    tick();
    rd_chk("wrap_00", A_CYC, 32'h0);
    chk("irq_wrap_pre", {31'd0, timer_irq}, 32'h0);
    tick();
    chk("irq_wrap", {31'd0, timer_irq}, 32'h1);
    wr(A_STAT, 32'h3);
    chk("irq_wrap_clr", {31'd0, timer_irq}, 32'h0);

    // ---- unmapped ----
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0);
    #1;
    chk("unmapped_rd_zero", dataram_rd, 32'h0);
    chk("bus_err_before", {31'd0, bus_err}, 32'h0);
    tick();
    idle();
    chk("bus_err_pulse", {31'd0, bus_err}, 32'h1);
    tick();
    chk("bus_err_one_cycle", {31'd0, bus_err}, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_1000, 32'hBAD0_BAD0);
    tick();
    drive(1'b0, 1'b1, 32'h0001_8000, 32'h0000_0077);
    chk("b2b_err_1", {31'd0, bus_err}, 32'h1);
    tick();
    idle();
    chk("b2b_err_2", {31'd0, bus_err}, 32'h1);
    tick();
    chk("b2b_err_end", {31'd0, bus_err}, 32'h0);
    rd_chk("ram_unchanged", 32'h0, 32'h1111_1111);
    chk("gpio_unchanged", {24'd0, gpio_out}, 32'hA5);
    tick();

    // ---- reset mid-run ----
    wr(A_GOUT, 32'hFF);
    w = cyc + 32'd3;
    wr(A_CMP, w);
    while (cyc != w) tick();
    tick();
    chk("irq_pre_rst", {31'd0, timer_irq}, 32'h1);
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0);
    tick();
    chk("bus_err_pre_rst", {31'd0, bus_err}, 32'h1);
    drive(1'b0, 1'b1, A_GOUT, 32'h5A);
    RST = 1'b1;
    #1;
    chk("arst_gpio_out", {24'd0, gpio_out}, 32'h0);
    chk("arst_irq", {31'd0, timer_irq}, 32'h0);
    chk("arst_bus_err", {31'd0, bus_err}, 32'h0);
    tick();
    chk("rst_wr_dropped", {24'd0, gpio_out}, 32'h0);
    idle();
    RST = 1'b0;
    cyc = 0;
    rd_chk("post_rst_cycle0", A_CYC, 32'h0);
    tick();
    rd_chk("post_rst_cycle1", A_CYC, 32'h1);
    rd_chk("post_rst_stat", A_STAT, 32'h0);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-side memory responder for the pipelined RV32I core; the other end of the core's MEM-stage interface (ena_wr, ena_rd, alu_out_ext, dataram_wr, dataram_rd).
- Decodes each access to either a word-addressed data RAM or a small MMIO register file. The MMIO file holds GPIO, a free-running cycle counter and a compare timer with interrupt flag.
- Read data is returned in the same cycle as ena_rd, because the core registers dataram_rd at the end of MEM.

Parameters:
RAM_WORDS, 1024, data RAM depth in 32-bit words (power of 2)
MMIO_BASE, 32'h0000_8000, base byte address of MMIO window (64-byte aligned)
GPIO_W, 8, GPIO input/output width (1..32)

Ports:
CLOCK  input  1  single clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
ena_rd  input  1  read request, MEM stage
ena_wr  input  1  write request, MEM stage
alu_out_ext  input  32  byte address
dataram_wr  input  32  write data
dataram_rd  output  32  read data, combinational from current state
gpio_in  input  GPIO_W  asynchronous external inputs
gpio_out  output  GPIO_W  GPIO_OUT register
timer_irq  output  1  timer interrupt level
bus_err  output  1  one-cycle pulse after an unmapped access

Behaviour:
- Address decode: bits [1:0] ignored; word access only.
  - RAM hit: addr < 4*RAM_WORDS.
  - MMIO hit: MMIO_BASE <= addr < MMIO_BASE+0x40.
  - Anything else is unmapped.
- RAM:
  - Write on rising edge when ena_wr && RAM hit; index = addr[log2(RAM_WORDS)+1:2].
  - Asynchronous read.
  - Contents are not reset.
- MMIO map (offset from MMIO_BASE):
  - 0x00 GPIO_OUT: RW, reset 0.
  - 0x04 GPIO_IN: RO, zero-extended. Driven by a 2-flop synchronizer on gpio_in; synchronizer flops reset to 0.
  - 0x08 CYCLE: RO, reset 0. Increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0. A read returns the pre-increment value.
  - 0x0C TIMER_CMP: RW, reset 0xFFFF_FFFF.
  - 0x10 TIMER_STAT: bit0 FLAG (write-1-to-clear), bit1 EN (RW). Reset 0. Other bits read 0.
  - 0x14..0x3C: read 0, writes ignored, no bus_err.
- Timer:
  - If EN && CYCLE == TIMER_CMP, FLAG is set on the next edge.
  - If the set condition and a W1C write to FLAG fall in the same cycle, set wins.
  - Writing EN=0 does not clear FLAG.
  - timer_irq = FLAG && EN; registered sources only, glitch-free.
- Read data:
  - dataram_rd = selected word when ena_rd.
  - dataram_rd = 0 when ena_rd is low or the address is unmapped.
- Simultaneous ena_rd && ena_wr to the same location: dataram_rd returns the old value; the new value is visible from the next cycle.
- Writes to RO registers (GPIO_IN, CYCLE) are ignored, no error.
- bus_err:
  - Registered; high for exactly one cycle after any cycle where (ena_rd || ena_wr) targets an unmapped address.
  - Back-to-back unmapped accesses keep it high continuously.
  - Reset value 0.
- Reset values of outputs: gpio_out=0, timer_irq=0, bus_err=0.
  - dataram_rd = 0 during reset for MMIO/unmapped addresses; for RAM addresses it follows the RAM array (array not reset).
- Reset asserted mid-operation: all MMIO registers, the synchronizer and bus_err return to reset values immediately (asynchronous).
  - A write in the same cycle as RST is dropped for MMIO.
  - RAM may or may not capture that write; don't-care for verification.
  - After RST deasserts, CYCLE reads 0 in the first cycle and 1 in the next.
- No wait states: every access completes in the cycle it is presented.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 next cycle -> dataram_rd = 0xDEADBEEF. Same-cycle rd+wr of 0x1234_5678 -> old 0xDEADBEEF that cycle, 0x1234_5678 on the next read. Read 0x0000_0013 returns the same word as 0x0000_0010.
- GPIO:
  - Write 0xA5 to MMIO_BASE+0x00 -> gpio_out = 0xA5 after the edge; reading back returns 0x0000_00A5.
  - Drive gpio_in=0x3C -> MMIO_BASE+0x04 reads 0x3C from the 2nd edge onward, still 0 after the 1st.
- Timer:
  - Set TIMER_CMP = current CYCLE+20 and EN=1 -> timer_irq rises exactly one edge after CYCLE == CMP.
  - Write TIMER_STAT=0x3 -> timer_irq falls.
  - W1C in the same cycle as a compare match -> FLAG stays 1.
- Counter wrap: force CYCLE to 0xFFFF_FFFE (bench backdoor or wait) -> reads 0xFFFF_FFFF, then 0x0000_0000. With TIMER_CMP=0 and EN=1, FLAG is set after the wrap.
- Unmapped: read 0x0001_0000 -> dataram_rd=0 that cycle, bus_err=1 for one cycle after. Two consecutive unmapped writes -> bus_err high for two cycles; RAM and MMIO unchanged.
- Reset mid-run: assert RST asynchronously with GPIO_OUT=0xFF, EN=1, FLAG=1 -> gpio_out=0, timer_irq=0, bus_err=0 without waiting for an edge. After release, CYCLE reads 0, then 1.
